reg_bank32: RTL
===============

REG_BANK32 -- requirements
Module: reg_bank32

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width per register.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width.
REQ-003 SHALL have parameter NREGS, default 32, register count (2**ADDR_W).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port we  input  1  write enable.
REQ-007 SHALL have port waddr  input  ADDR_W  write register index.
REQ-008 SHALL have port wdata  input  DATA_W  write data.
REQ-009 SHALL have port raddr1  input  ADDR_W  read port 1 index.
REQ-010 SHALL have port raddr2  input  ADDR_W  read port 2 index.
REQ-011 SHALL have port rdata1  output  DATA_W  read port 1 data.
REQ-012 SHALL have port rdata2  output  DATA_W  read port 2 data.
REQ-013 SHALL have port wr_onehot  output  NREGS  decoded per-register write strobe.

Function
REQ-014 SHALL write wdata into register[waddr] at the rising edge when we=1, rst=0, waddr!=0.
REQ-015 SHALL ignore writes to index 0; register 0 reads 0 at all times.
REQ-016 SHALL drive rdata1/rdata2 combinationally from storage selected by raddr1/raddr2 (zero-cycle read latency).
REQ-017 SHALL drive wr_onehot combinationally: bit waddr set when we=1 and waddr!=0; all zero otherwise; bit 0 never set.
REQ-018 SHALL keep every register not addressed by an active write unchanged across the edge.
REQ-019 SHALL give both read ports identical data when raddr1=raddr2.
REQ-020 SHALL give rst priority over we: a write presented in a reset cycle is discarded.
REQ-021 SHALL make a write visible on rdataN in the cycle after the edge when raddrN=waddr (without bypass).

Reset
REQ-022 SHALL clear all NREGS registers to 0 at the rising edge where rst=1.
REQ-023 SHALL show rdata1=rdata2=0 for every address from the cycle after a reset edge until the first write.
REQ-024 SHALL, on reset asserted between two writes, lose the pending write and clear prior contents.

Configuration
REQ-025 SHALL, with macro REGFILE_BYPASS_EN defined, forward wdata to rdataN in the same cycle when we=1, rst=0, waddr!=0 and raddrN=waddr.
REQ-026 SHALL, with REGFILE_BYPASS_EN defined, never forward for waddr=0 or during rst=1.
REQ-027 SHALL, without REGFILE_BYPASS_EN, present the old stored value during the write cycle.

Structure
REQ-028 SHALL take DATA_W, ADDR_W, NREGS defaults and ZERO_REG index constant from shared package regfile_pkg.
REQ-029 SHALL implement the write-address decode in sub-module decoder5x32 (ADDR_W to NREGS one-hot, with enable) feeding wr_onehot.
REQ-030 SHALL implement each read port as a 32:1 select over storage, with index 0 hardwired to 0.

Verification
REQ-031 SHALL check reset: preload x5=0xDEADBEEF, assert rst one cycle -> rdata for raddr 0..31 all 0x00000000.
REQ-032 SHALL check write/read: write x1..x31 with value index+0x100 -> raddr1=7 gives 0x107, raddr2=31 gives 0x11F; wr_onehot=1<<index during each write.
REQ-033 SHALL check x0: we=1, waddr=0, wdata=0xFFFFFFFF -> rdata1 with raddr1=0 stays 0, wr_onehot=0.
REQ-034 SHALL check same-cycle read of write target: x3=0x11, write 0x22 with raddr1=3 -> 0x11 in cycle (0x22 with REGFILE_BYPASS_EN), 0x22 next cycle in both builds.
REQ-035 SHALL check reset priority: rst=1 and we=1, waddr=4, wdata=0xA5A5A5A5 together -> x4 reads 0 afterwards, no bypass during that cycle.
REQ-036 SHALL check dual port: raddr1=raddr2=9 after writing 0x1234 to x9 -> both ports read 0x00001234.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared sizing constants for the 32-entry register bank and its write decoder.
// Register ZERO_REG is architecturally hardwired to zero and never stored.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NREGS_DEF  = 1 << ADDR_W_DEF;
    localparam int ZERO_REG   = 0;

    function automatic logic isZeroReg(input int idx);
        return (idx == ZERO_REG);
    endfunction

endpackage

// File: rtl/decoder5x32.sv
// Binary-to-one-hot decoder with enable: i_addr selects one of NREGS strobes.
// All strobes stay low when the enable is clear.
module decoder5x32
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NREGS  = NREGS_DEF
) (
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [NREGS-1:0]  o_onehot
);

    always_comb begin
        o_onehot = '0;
        for (int i = 0; i < NREGS; i++) begin
            o_onehot[i] = i_en && (i_addr == ADDR_W'(i));
        end
    end

endmodule

// File: rtl/reg_bank32.sv
// Two-read / one-write register bank with x0 hardwired to zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module reg_bank32
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NREGS  = NREGS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic [NREGS-1:0]  wr_onehot
);

    // Only entries 1..NREGS-1 hold state; the zero register has no storage.
    logic [DATA_W-1:0] r_regs [1:NREGS-1];

    logic              w_decEn;
    logic [NREGS-1:0]  w_wrOnehot;
    logic [DATA_W-1:0] w_rdata1;
    logic [DATA_W-1:0] w_rdata2;

    assign w_decEn = we && (waddr != ADDR_W'(ZERO_REG));

    decoder5x32 #(
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) u_wrDecoder (
        .i_en     (w_decEn),
        .i_addr   (waddr),
        .o_onehot (w_wrOnehot)
    );

    assign wr_onehot = w_wrOnehot;

    // Reset wins over any write presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (w_wrOnehot[i]) begin
                    r_regs[i] <= wdata;
                end
            end
        end
    end

    always_comb begin
        w_rdata1 = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (raddr1 == ADDR_W'(i)) begin
                w_rdata1 = r_regs[i];
            end
        end
    end

    always_comb begin
        w_rdata2 = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (raddr2 == ADDR_W'(i)) begin
                w_rdata2 = r_regs[i];
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Forwarding is suppressed in reset cycles since that write never lands.
    logic w_wrActive;

    assign w_wrActive = w_decEn && !rst;
    assign rdata1 = (w_wrActive && (raddr1 == waddr)) ? wdata : w_rdata1;
    assign rdata2 = (w_wrActive && (raddr2 == waddr)) ? wdata : w_rdata2;
`else
    assign rdata1 = w_rdata1;
    assign rdata2 = w_rdata2;
`endif

endmodule
